// File: rtl/fixed_point_mac.sv
// Pipelined signed fixed-point multiply-accumulate with a valid/ready
// handshake on both sides.
//
// Ports:
//   system1000      clock, all state changes on the rising edge
//   system1000_rst  synchronous reset, active-high
//   in_valid        operand pair valid
//   in_ready        block accepts an operand pair this cycle
//   in_a, in_b      signed Q(WIDTH-FRAC).FRAC operands
//   out_valid       result valid, held until taken
//   out_ready       consumer takes the result this cycle
//   out_data        rounded and saturated block sum, same format as operands
//   out_sat         out_data was clipped, qualified by out_valid
//
// Each operand pair is registered (S1), multiplied exactly (S2) and added
// into a guarded accumulator (S3). Every ACC_LEN products the sum is
// rounded half toward +inf, clipped to WIDTH bits and loaded into the
// output register. One global enable stalls every stage while a result
// waits for the consumer.

module fixed_point_mac #(
    parameter int WIDTH     = 9,
    parameter int FRAC      = 4,
    parameter int ACC_LEN   = 4,
    parameter int ACC_GUARD = 4
) (
    input  logic                    system1000,
    input  logic                    system1000_rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_a,
    input  logic signed [WIDTH-1:0] in_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_data,
    output logic                    out_sat
);

    localparam int PW = 2 * WIDTH;
    localparam int AW = PW + ACC_GUARD;
    localparam int CW = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;

    localparam logic [CW-1:0] LAST = CW'(ACC_LEN - 1);

    // Rounding constant and clip bounds, one bit wider than the accumulator
    // so the rounding add can never wrap.
    localparam logic signed [AW:0] HALF = (AW + 1)'(1) <<< (FRAC - 1);
    localparam logic signed [AW:0] MAXV =
        $signed({{(AW - WIDTH + 2){1'b0}}, {(WIDTH - 1){1'b1}}});
    localparam logic signed [AW:0] MINV = ~MAXV;

    logic en;

    logic                    s1_valid;
    logic signed [WIDTH-1:0] s1_a;
    logic signed [WIDTH-1:0] s1_b;

    logic                    s2_valid;
    logic signed [PW-1:0]    s2_p;

    logic signed [AW-1:0]    acc;
    logic [CW-1:0]           count;

    logic                    done;
    logic signed [AW-1:0]    sum;
    logic signed [AW:0]      rnd;
    logic signed [AW:0]      shr;
    logic signed [WIDTH-1:0] res;
    logic                    clip;

    assign en       = !(out_valid && !out_ready);
    assign in_ready = en && !system1000_rst;

    // Block completion: the last product of a block sits in S2 now.
    assign done = s2_valid && (count == LAST);
    assign sum  = acc + {{ACC_GUARD{s2_p[PW-1]}}, s2_p};
    assign rnd  = {sum[AW-1], sum} + HALF;
    assign shr  = rnd >>> FRAC;

    always_comb begin
        res  = shr[WIDTH-1:0];
        clip = 1'b0;
        if (shr > MAXV) begin
            res  = MAXV[WIDTH-1:0];
            clip = 1'b1;
        end else if (shr < MINV) begin
            res  = MINV[WIDTH-1:0];
            clip = 1'b1;
        end
    end

    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s2_valid <= 1'b0;
            s2_p     <= '0;
        end else if (en) begin
            s1_valid <= in_valid;
            s1_a     <= in_a;
            s1_b     <= in_b;
            s2_valid <= s1_valid;
            s2_p     <= s1_a * s1_b;
        end
    end

    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            acc   <= '0;
            count <= '0;
        end else if (en && s2_valid) begin
            if (done) begin
                acc   <= '0;
                count <= '0;
            end else begin
                acc   <= sum;
                count <= count + CW'(1);
            end
        end
    end

    // When stalled (en=0) the output register holds; otherwise a new
    // result overwrites, and a taken result without a successor clears.
    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (en) begin
            if (done) begin
                out_valid <= 1'b1;
                out_data  <= res;
                out_sat   <= clip;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fixed_point_mac.sv
// Directed bench for fixed_point_mac with a result scoreboard.
// Expected block results are modelled when each pair is accepted.

module tb_fixed_point_mac;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic signed [8:0]   in_a = '0;
    logic signed [8:0]   in_b = '0;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic signed [8:0]   out_data;
    logic                out_sat;

    int applied = 0;
    int miscompares = 0;

    int cyc = 0;
    int accepted = 0;
    int waits = 0;
    int last_acc_cyc = 0;
    int macc = 0;
    int mcnt = 0;

    logic signed [8:0] exp_d[$];
    logic              exp_s[$];

    fixed_point_mac #(
        .WIDTH(9), .FRAC(4), .ACC_LEN(4), .ACC_GUARD(4)
    ) dut (
        .system1000(clk),
        .system1000_rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_a(in_a),
        .in_b(in_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string tag, int got, int want);
        applied++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    // Result scoreboard: every handshake pops one expected value.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            applied++;
            assert (exp_d.size() > 0) else begin
                miscompares++;
                $error("FAIL unexpected_result got=%0d want=none",
                       out_data);
            end
            if (exp_d.size() > 0) begin
                logic signed [8:0] d;
                logic s;
                d = exp_d.pop_front();
                s = exp_s.pop_front();
                check("result_data", int'(out_data), int'(d));
                check("result_sat", int'(out_sat), int'(s));
            end
        end
    end

    function automatic void model(int a, int b);
        int r;
        logic signed [8:0] d;
        logic s;
        macc += a * b;
        mcnt++;
        if (mcnt == 4) begin
            r = (macc + 8) >>> 4;
            s = 1'b0;
            if (r > 255) begin
                r = 255;
                s = 1'b1;
            end else if (r < -256) begin
                r = -256;
                s = 1'b1;
            end
            d = 9'(r);
            exp_d.push_back(d);
            exp_s.push_back(s);
            macc = 0;
            mcnt = 0;
        end
    endfunction

    // Offer one pair; returns one cycle after acceptance, at posedge+1.
    task automatic send(int a, int b, int bound);
        int n;
        in_valid = 1'b1;
        in_a = 9'(a);
        in_b = 9'(b);
        n = 0;
        @(negedge clk);
        while (!in_ready && n < bound) begin
            waits++;
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            check("accept_timeout", 0, 1);
        end else begin
            last_acc_cyc = cyc;
            accepted++;
            model(a, b);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(string tag);
        int n;
        n = 0;
        while (exp_d.size() > 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(tag, exp_d.size(), 0);
        idle(2);
    endtask

    task automatic do_reset(int n);
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (n) begin
            @(negedge clk);
            check("rst_in_ready", int'(in_ready), 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        macc = 0;
        mcnt = 0;
        exp_d.delete();
        exp_s.delete();
    endtask

    initial begin
        int n;
        int acc0;
        int pushed;

        // Reset state
        do_reset(3);
        @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_sat", int'(out_sat), 0);
        check("post_rst_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;

        // 1. Unit products, latency n+3
        repeat (4) send(16, 16, 5);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 10) begin
            n++;
            @(negedge clk);
        end
        check("latency", cyc - last_acc_cyc, 3);
        @(posedge clk);
        #1;
        drain("t1_drain");

        // 2. Saturation both ways
        repeat (4) send(255, 255, 5);
        repeat (4) send(255, -256, 5);
        drain("t2_drain");

        // 3. Rounding
        send(1, 8, 5);
        repeat (3) send(0, 0, 5);
        send(1, 7, 5);
        repeat (3) send(0, 0, 5);
        send(-1, 8, 5);
        repeat (3) send(0, 0, 5);
        send(-1, 9, 5);
        repeat (3) send(0, 0, 5);
        drain("t3_drain");

        // 4. Backpressure
        out_ready = 1'b0;
        acc0 = accepted;
        fork
            begin
                repeat (8) send(16, 16, 100);
            end
            begin
                int k;
                int held;
                k = 0;
                @(negedge clk);
                while (!out_valid && k < 20) begin
                    k++;
                    @(negedge clk);
                end
                check("t4_stall_valid", int'(out_valid), 1);
                held = accepted;
                repeat (10) begin
                    check("t4_hold_data", int'(out_data), 64);
                    check("t4_hold_sat", int'(out_sat), 0);
                    check("t4_in_ready", int'(in_ready), 0);
                    @(negedge clk);
                end
                check("t4_no_accept", accepted, held);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain("t4_drain");
        check("t4_accepted", accepted - acc0, 8);

        // 5. Reset mid-block
        repeat (2) send(100, 100, 5);
        do_reset(1);
        repeat (3) begin
            @(negedge clk);
            check("t5_valid_low", int'(out_valid), 0);
        end
        @(posedge clk);
        #1;
        pushed = 0;
        repeat (4) send(16, 16, 5);
        pushed = exp_d.size();
        check("t5_one_result", pushed, 1);
        drain("t5_drain");

        // 6. Back-to-back blocks
        waits = 0;
        repeat (8) send(16, 16, 5);
        repeat (4) send(32, 16, 5);
        check("t6_no_wait", waits, 0);
        drain("t6_drain");

        $display("== %0d vectors applied, %0d miscompares ==",
                 applied, miscompares);
        $finish;
    end

endmodule
